// File: rtl/vc_pop_arbiter.sv
// vc_pop_arbiter: pops the vc0/vc1 FIFOs, routes each word to d0/d1 by its destination bit,
// owns the FIFO thresholds and a sticky error state. Optional macro ROUND_ROBIN_EN selects alternating grant.
module vc_pop_arbiter #(
    parameter int DATA_SIZE = 6,
    parameter int DEST_BIT  = DATA_SIZE - 1
) (
    input  logic                 clk,
    input  logic                 reset_L,
    input  logic                 init,
    input  logic [DATA_SIZE-1:0] umbral_af,
    input  logic [DATA_SIZE-1:0] umbral_ae,
    input  logic                 fifo_empty_vc0,
    input  logic                 fifo_empty_vc1,
    input  logic [DATA_SIZE-1:0] data_vc0,
    input  logic [DATA_SIZE-1:0] data_vc1,
    input  logic                 pause_d0,
    input  logic                 pause_d1,
    input  logic [3:0]           fifo_error,
    output logic                 pop_vc0,
    output logic                 pop_vc1,
    output logic                 push_d0,
    output logic                 push_d1,
    output logic [DATA_SIZE-1:0] data_out,
    output logic [DATA_SIZE-1:0] afvf,
    output logic [DATA_SIZE-1:0] aevf,
    output logic                 idle,
    output logic                 error_out,
    output logic [2:0]           state
);

    typedef enum logic [2:0] {
        ST_RESET  = 3'd0,
        ST_INIT   = 3'd1,
        ST_IDLE   = 3'd2,
        ST_ACTIVE = 3'd3,
        ST_ERROR  = 3'd4
    } state_e;

    state_e               state_q, state_d;
    logic [DATA_SIZE-1:0] afvf_q, afvf_d;
    logic [DATA_SIZE-1:0] aevf_q, aevf_d;
    logic                 pop_q, pop_d;
    logic                 src_q, src_d;
    logic                 any_error;
    logic                 grant_ok;
    logic [DATA_SIZE-1:0] data_sel;

    assign any_error = |fifo_error;

    // NOTE: every signal assigned in an always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_RESET:  state_d = ST_INIT;
            ST_INIT:   if (!init) state_d = ST_IDLE;
            ST_IDLE: begin
                if (init)                                  state_d = ST_INIT;
                else if (!fifo_empty_vc0 || !fifo_empty_vc1) state_d = ST_ACTIVE;
            end
            ST_ACTIVE: begin
                if (init)                                           state_d = ST_INIT;
                else if (fifo_empty_vc0 && fifo_empty_vc1 && !pop_q) state_d = ST_IDLE;
            end
            ST_ERROR:  state_d = ST_ERROR;
            default:   state_d = ST_RESET;
        endcase
        // Errors override everything once out of RESET; only reset_L leaves ERROR.
        if (state_q != ST_RESET && any_error) state_d = ST_ERROR;
    end

    always_comb begin
        afvf_d = afvf_q;
        aevf_d = aevf_q;
        if (state_q == ST_INIT) begin
            afvf_d = umbral_af;
            aevf_d = umbral_ae;
        end
    end

    assign grant_ok = (state_q == ST_ACTIVE) && !init && !any_error && !pause_d0 && !pause_d1;

`ifdef ROUND_ROBIN_EN
    // last_q = 1 means vc1 won the most recent grant.
    logic last_q, last_d;

    always_comb begin
        pop_vc0 = 1'b0;
        pop_vc1 = 1'b0;
        if (!fifo_empty_vc0 && !fifo_empty_vc1) begin
            pop_vc0 = grant_ok && last_q;
            pop_vc1 = grant_ok && !last_q;
        end else begin
            pop_vc0 = grant_ok && !fifo_empty_vc0;
            pop_vc1 = grant_ok && !fifo_empty_vc1;
        end
        last_d = last_q;
        if (pop_vc1)      last_d = 1'b1;
        else if (pop_vc0) last_d = 1'b0;
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) last_q <= 1'b0;
        else          last_q <= last_d;
    end
`else
    always_comb begin
        pop_vc0 = grant_ok && !fifo_empty_vc0;
        pop_vc1 = grant_ok && fifo_empty_vc0 && !fifo_empty_vc1;
    end
`endif

    // Route stage: the FIFO presents popped data one cycle later, so remember that a pop happened and from where.
    always_comb begin
        pop_d = pop_vc0 || pop_vc1;
        src_d = pop_vc1;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state_q <= ST_RESET;
            afvf_q  <= '0;
            aevf_q  <= '0;
            pop_q   <= 1'b0;
            src_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            afvf_q  <= afvf_d;
            aevf_q  <= aevf_d;
            pop_q   <= pop_d;
            src_q   <= src_d;
        end
    end

    always_comb begin
        data_sel = src_q ? data_vc1 : data_vc0;
        data_out = pop_q ? data_sel : '0;
        push_d0  = pop_q && !data_out[DEST_BIT];
        push_d1  = pop_q && data_out[DEST_BIT];
    end

    assign afvf      = afvf_q;
    assign aevf      = aevf_q;
    assign idle      = (state_q == ST_IDLE);
    assign error_out = (state_q == ST_ERROR);
    assign state     = state_q;

endmodule

// File: tb/tb_vc_pop_arbiter.sv
// Randomised bench for vc_pop_arbiter: bench-side VC FIFOs and a phase/grant reference model feed
// an expected-word queue that an independent monitor checks against every push.
module tb_vc_pop_arbiter;

    localparam int DS = 6;
    localparam int P_RESET = 0, P_INIT = 1, P_IDLE = 2, P_ACTIVE = 3, P_ERROR = 4;

    logic          clk = 1'b0;
    logic          reset_L;
    logic          init;
    logic [DS-1:0] umbral_af, umbral_ae;
    logic          fifo_empty_vc0, fifo_empty_vc1;
    logic [DS-1:0] data_vc0, data_vc1;
    logic          pause_d0, pause_d1;
    logic [3:0]    fifo_error;
    logic          pop_vc0, pop_vc1, push_d0, push_d1;
    logic [DS-1:0] data_out, afvf, aevf;
    logic          idle, error_out;
    logic [2:0]    state;

    vc_pop_arbiter #(.DATA_SIZE(DS), .DEST_BIT(DS-1)) dut (
        .clk(clk), .reset_L(reset_L), .init(init),
        .umbral_af(umbral_af), .umbral_ae(umbral_ae),
        .fifo_empty_vc0(fifo_empty_vc0), .fifo_empty_vc1(fifo_empty_vc1),
        .data_vc0(data_vc0), .data_vc1(data_vc1),
        .pause_d0(pause_d0), .pause_d1(pause_d1), .fifo_error(fifo_error),
        .pop_vc0(pop_vc0), .pop_vc1(pop_vc1), .push_d0(push_d0), .push_d1(push_d1),
        .data_out(data_out), .afvf(afvf), .aevf(aevf),
        .idle(idle), .error_out(error_out), .state(state)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Bench-side VC FIFO contents, expected pushes, and reference model state.
    logic [DS-1:0] q0[$];
    logic [DS-1:0] q1[$];
    logic [DS-1:0] exp_q[$];
    int            phase;
    bit            inflight;
    bit            last_vc;
    logic [DS-1:0] exp_af, exp_ae;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        phase    = P_RESET;
        inflight = 1'b0;
        last_vc  = 1'b0;
        exp_af   = '0;
        exp_ae   = '0;
        exp_q.delete();
        q0.delete();
        q1.delete();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " pop_vc0"},   pop_vc0, 0);
        check({tag, " pop_vc1"},   pop_vc1, 0);
        check({tag, " push_d0"},   push_d0, 0);
        check({tag, " push_d1"},   push_d1, 0);
        check({tag, " data_out"},  data_out, 0);
        check({tag, " afvf"},      afvf, 0);
        check({tag, " aevf"},      aevf, 0);
        check({tag, " idle"},      idle, 0);
        check({tag, " error_out"}, error_out, 0);
        check({tag, " state"},     state, 0);
    endtask

    // One clock cycle: caller sets stimulus right after a falling edge, then calls step.
    task automatic step(input bit abort);
        bit g0, g1, err, any_word;
        int nxt;
        fifo_empty_vc0 = (q0.size() == 0);
        fifo_empty_vc1 = (q1.size() == 0);
        #1;
        err      = |fifo_error;
        any_word = (q0.size() > 0) || (q1.size() > 0);
        g0 = 1'b0;
        g1 = 1'b0;
        if (phase == P_ACTIVE && !init && !err && !pause_d0 && !pause_d1) begin
            if (q0.size() > 0 && q1.size() > 0) begin
`ifdef ROUND_ROBIN_EN
                if (last_vc) g0 = 1'b1; else g1 = 1'b1;
`else
                g0 = 1'b1;
`endif
            end else if (q0.size() > 0) g0 = 1'b1;
            else if (q1.size() > 0)     g1 = 1'b1;
        end
        check("pop_vc0", pop_vc0, g0);
        check("pop_vc1", pop_vc1, g1);
        check("state", state, phase);
        check("idle", idle, phase == P_IDLE);
        check("error_out", error_out, phase == P_ERROR);
        check("afvf", afvf, exp_af);
        check("aevf", aevf, exp_ae);
        if (g0) exp_q.push_back(q0[0]);
        if (g1) exp_q.push_back(q1[0]);

        case (phase)
            P_RESET:  nxt = P_INIT;
            P_INIT:   nxt = init ? P_INIT : P_IDLE;
            P_IDLE:   nxt = init ? P_INIT : (any_word ? P_ACTIVE : P_IDLE);
            P_ACTIVE: nxt = init ? P_INIT : ((!any_word && !inflight) ? P_IDLE : P_ACTIVE);
            default:  nxt = P_ERROR;
        endcase
        if (phase != P_RESET && err) nxt = P_ERROR;

        @(posedge clk);
        #1;
        if (g0) begin data_vc0 = q0.pop_front(); last_vc = 1'b0; end
        if (g1) begin data_vc1 = q1.pop_front(); last_vc = 1'b1; end
        if (phase == P_INIT) begin
            exp_af = umbral_af;
            exp_ae = umbral_ae;
        end
        phase    = nxt;
        inflight = g0 || g1;
        if (abort) begin
            check("abort had in-flight word", inflight, 1);
            reset_L = 1'b0;
            model_reset();
            #1;
            check_all_zero("abort");
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset_L    = 1'b0;
        fifo_error = '0;
        model_reset();
        repeat (2) @(negedge clk);
        reset_L = 1'b1;
    endtask

    task automatic bring_up(input logic [DS-1:0] af, input logic [DS-1:0] ae);
        init = 1'b1; umbral_af = af; umbral_ae = ae;
        step(0);
        step(0);
        init = 1'b0;
        step(0);
        step(0);
    endtask

    // Monitor: every falling edge, the word expected from last cycle's pop must be on the push lines.
    initial begin
        logic [DS-1:0] w;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                w = exp_q.pop_front();
                check("push_d0", push_d0, !w[DS-1]);
                check("push_d1", push_d1, w[DS-1]);
                check("data_out", data_out, w);
            end else begin
                check("push_d0 quiet", push_d0, 0);
                check("push_d1 quiet", push_d1, 0);
                check("data_out quiet", data_out, 0);
            end
        end
    end

    initial begin
        int guard;
        reset_L = 1'b0; init = 1'b0; umbral_af = '0; umbral_ae = '0;
        fifo_empty_vc0 = 1'b1; fifo_empty_vc1 = 1'b1;
        data_vc0 = '0; data_vc1 = '0; pause_d0 = 1'b0; pause_d1 = 1'b0; fifo_error = '0;
        model_reset();
        #2;
        check_all_zero("reset");
        @(negedge clk);
        @(negedge clk);
        reset_L = 1'b1;

        // Threshold load, then the values hold once out of INIT.
        bring_up(6'd3, 6'd1);
        check("afvf loaded", afvf, 3);
        check("aevf loaded", aevf, 1);
        check("idle after init", idle, 1);
        umbral_af = 6'd7; umbral_ae = 6'd6;
        step(0);

        // Two words from vc0: one to d0, one to d1.
        q0.push_back(6'h05); q0.push_back(6'h25);
        repeat (6) step(0);

        // Both VCs loaded at once.
        for (int i = 0; i < 3; i++) begin
            q0.push_back(6'($urandom_range(0, 63)));
            q1.push_back(6'($urandom_range(0, 63)));
        end
        repeat (10) step(0);

        // Pause raised right after a pop: in-flight word pushes, pops resume after pause drops.
        for (int i = 0; i < 4; i++) q1.push_back(6'($urandom_range(0, 63)));
        step(0);
        step(0);
        pause_d1 = 1'b1;
        repeat (3) step(0);
        pause_d1 = 1'b0;
        repeat (6) step(0);

        // Randomised traffic with an init burst in the middle.
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 9) < 4) q0.push_back(6'($urandom_range(0, 63)));
            if ($urandom_range(0, 9) < 4) q1.push_back(6'($urandom_range(0, 63)));
            pause_d0 = ($urandom_range(0, 7) == 0);
            pause_d1 = ($urandom_range(0, 7) == 0);
            init     = (i == 150) || (i == 151);
            if (i == 150) begin
                umbral_af = 6'($urandom_range(0, 63));
                umbral_ae = 6'($urandom_range(0, 63));
            end
            step(0);
        end
        pause_d0 = 1'b0; pause_d1 = 1'b0; init = 1'b0;
        guard = 0;
        while ((q0.size() + q1.size()) > 0 && guard < 2000) begin
            step(0);
            guard++;
        end
        repeat (3) step(0);
        check("vc fifos drained", q0.size() + q1.size(), 0);
        check("idle after drain", idle, 1);

        // Error in ACTIVE: pops stop at once, in-flight word pushes, ERROR sticks.
        for (int i = 0; i < 4; i++) q0.push_back(6'($urandom_range(0, 63)));
        step(0);
        step(0);
        fifo_error = 4'b0100;
        step(0);
        fifo_error = 4'b0000;
        repeat (4) step(0);
        check("error sticky", error_out, 1);
        do_reset();
        bring_up(6'd10, 6'd2);

        // Reset dropped while a word is in flight: nothing is pushed.
        for (int i = 0; i < 3; i++) q0.push_back(6'($urandom_range(0, 63)));
        step(0);
        step(1);
        @(negedge clk);
        reset_L = 1'b1;
        bring_up(6'd4, 6'd1);
        q1.push_back(6'h2a);
        repeat (4) step(0);

        check("expected queue drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
